// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The master drives start and the operands; the slave (the divider) drives status and results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (output start, a, b, input busy, done, q, r, div_by_zero);
  modport slave  (input start, a, b, output busy, done, q, r, div_by_zero);
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider producing one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands; the default build is unsigned only.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] dvd_reg, dvs_reg, p_reg, q_reg, r_reg;
  logic [CW-1:0]    cnt_reg;
  logic             dbz_reg;
  logic             accept;

  logic [WIDTH:0]   p_shift, p_diff;
  logic             qbit;
  logic [WIDTH-1:0] p_new, q_new;
  logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;

  assign accept = (state_reg == IDLE) && bus.start;

  // One restoring step; the extra subtractor bit keeps the borrow out of the top remainder bit.
  always_comb begin
    p_shift = {p_reg, dvd_reg[WIDTH-1]};
    p_diff  = p_shift - {1'b0, dvs_reg};
    qbit    = ~p_diff[WIDTH];
    p_new   = qbit ? p_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
    q_new   = {dvd_reg[WIDTH-2:0], qbit};
  end

`ifdef SEQ_DIV_SIGNED_EN
  logic qneg_reg, rneg_reg;

  assign a_mag = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign q_fin = qneg_reg ? (~q_new + 1'b1) : q_new;
  assign r_fin = rneg_reg ? (~p_new + 1'b1) : p_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qneg_reg <= 1'b0;
      rneg_reg <= 1'b0;
    end else if (accept) begin
      qneg_reg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      rneg_reg <= bus.a[WIDTH-1];
    end
  end
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
  assign q_fin = q_new;
  assign r_fin = p_new;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (bus.b == '0) ? DONE : CALC;
      CALC:    if (cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_reg == CALC);
    bus.done = (state_reg == DONE);
  end

  // The dividend register doubles as the quotient accumulator as bits shift out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg <= '0;
      dvs_reg <= '0;
      p_reg   <= '0;
      cnt_reg <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      dvd_reg <= a_mag;
      dvs_reg <= b_mag;
      p_reg   <= '0;
      cnt_reg <= CW'(WIDTH - 1);
      dbz_reg <= (bus.b == '0);
      if (bus.b == '0) begin
        q_reg <= '1;
        r_reg <= bus.a;
      end
    end else if (state_reg == CALC) begin
      p_reg   <= p_new;
      dvd_reg <= q_new;
      cnt_reg <= cnt_reg - 1'b1;
      if (cnt_reg == '0) begin
        q_reg <= q_fin;
        r_reg <= r_fin;
      end
    end
  end

  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, handshake corner cases and random operands against a
// plain-arithmetic reference. Define SEQ_DIV_SIGNED_EN to exercise the signed build at 8 bits.
module tb_seq_divider;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int W = 8;
  localparam int NRAND = 1000;
`else
  localparam int W = 32;
  localparam int NRAND = 300;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.WIDTH(W)) bus ();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end
`ifdef SEQ_DIV_SIGNED_EN
    else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      q = a;
      r = '0;
    end else begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end
`else
    else begin
      q = a / b;
      r = a % b;
    end
`endif
  endfunction

  // Issues one operation, scrambles the operand inputs after acceptance, returns at the done cycle.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    lat = 0;
    busy_cnt = 0;
    for (int n = 1; n <= W + 10; n++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    q = bus.q;
    r = bus.r;
    dz = bus.div_by_zero;
    $display("div a=%h b=%h q=%h r=%h dz=%b lat=%0d busy=%0d", a, b, q, r, dz, lat, busy_cnt);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [W-1:0] q, r;
    logic dz;
    int lat, bc;
    do_div(v.a, v.b, q, r, dz, lat, bc);
    chk({tag, " q"}, 64'(q), 64'(v.q));
    chk({tag, " r"}, 64'(r), 64'(v.r));
    chk({tag, " dz"}, 64'(dz), 64'(v.dz));
    chk({tag, " latency"}, 64'(lat), (v.b == '0) ? 64'd1 : 64'(W + 1));
    chk({tag, " busy cycles"}, 64'(bc), (v.b == '0) ? 64'd0 : 64'(W));
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] q, r, eq, er, ra, rb;
    logic dz, edz;
    int lat, bc, ndone;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;

`ifdef SEQ_DIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0});
    vecs.push_back('{8'h80, 8'h01, 8'h80, 8'h00, 1'b0});
    vecs.push_back('{8'hF9, 8'hF9, 8'h01, 8'h00, 1'b0});
    vecs.push_back('{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0});
    vecs.push_back('{8'hFB, 8'h00, 8'hFF, 8'hFB, 1'b1});
`else
    vecs.push_back('{32'd4, 32'd2, 32'd2, 32'd0, 1'b0});
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    vecs.push_back('{32'd3, 32'd10, 32'd0, 32'd3, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0});
    vecs.push_back('{32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1});
    vecs.push_back('{32'd7, 32'd7, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0});
    vecs.push_back('{32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset q", 64'(bus.q), 64'd0);
    chk("reset r", 64'(bus.r), 64'd0);
    chk("reset dz", 64'(bus.div_by_zero), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

    // start pulsed mid-division must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(100);
    bus.b = W'(7);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    q = '0;
    r = '0;
    for (int n = 1; n <= W + 10; n++) begin
      @(negedge clk);
      if (n == 5) begin
        bus.start = 1'b1;
        bus.a = W'(9);
        bus.b = W'(3);
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        q = bus.q;
        r = bus.r;
      end
    end
    $display("busy-start a=100 b=7 q=%h r=%h done_pulses=%0d", q, r, ndone);
    chk("busy start done pulses", 64'(ndone), 64'd1);
    chk("busy start q", 64'(q), 64'd14);
    chk("busy start r", 64'(r), 64'd2);
    run_vec("after busy", '{W'(9), W'(3), W'(3), W'(0), 1'b0});

    // start presented only during the done cycle must be ignored
    do_div(W'(50), W'(5), q, r, dz, lat, bc);
    chk("done-cycle op q", 64'(q), 64'd10);
    bus.start = 1'b1;
    bus.a = W'(9);
    bus.b = W'(3);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("start in done busy", 64'(bus.busy), 64'd0);
    chk("start in done q held", 64'(bus.q), 64'd10);

    // Asynchronous reset in the middle of a division
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(100);
    bus.b = W'(7);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort q", 64'(bus.q), 64'd0);
    chk("abort r", 64'(bus.r), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < W + 5; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    $display("abort: activity cycles after reset=%0d", ndone);
    chk("abort no activity", 64'(ndone), 64'd0);
    run_vec("after reset", '{W'(20), W'(6), W'(3), W'(2), 1'b0});

    // Random operands against the reference model
    for (int i = 0; i < NRAND; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        3:       rb = ra;
        default: rb = W'($urandom) >> $urandom_range(0, W - 1);
      endcase
      ref_div(ra, rb, eq, er, edz);
      do_div(ra, rb, q, r, dz, lat, bc);
      chk($sformatf("rand%0d q", i), 64'(q), 64'(eq));
      chk($sformatf("rand%0d r", i), 64'(r), 64'(er));
      chk($sformatf("rand%0d dz", i), 64'(dz), 64'(edz));
      chk($sformatf("rand%0d latency", i), 64'(lat), (rb == '0) ? 64'd1 : 64'(W + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
